// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: two-flop synchroniser, centre sampling with start-glitch rejection,
// framing-error detection and a one-entry valid/ready holding register with overrun pulse.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun
);
    // state     | meaning
    // IDLE      | line idle, waiting for rxd_s low
    // START     | timing to start-bit centre, glitch check
    // DATA      | sampling 8 data bits, LSB first
    // STOP      | timing to stop-bit centre
    // WAIT_HIGH | stop bit was low; wait for line to return high
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    state_t      state, state_next;
    logic        sync1, rxd_s;
    logic [CW-1:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tc, stop_ok, stop_bad;

    assign tc = (cnt == '0);

    always_comb begin
        state_next = state;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE:      if (!rxd_s) state_next = START;
            START:     if (tc) state_next = rxd_s ? IDLE : DATA;
            DATA:      if (tc && bit_idx == 3'd7) state_next = STOP;
            STOP: begin
                if (tc) begin
                    if (rxd_s) begin
                        state_next = IDLE;
                        stop_ok    = 1'b1;
                    end else begin
                        state_next = WAIT_HIGH;
                        stop_bad   = 1'b1;
                    end
                end
            end
            WAIT_HIGH: if (rxd_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            rxd_s       <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
            state <= state_next;
            busy  <= (state_next != IDLE);

            // Down-counter reloads at every sample point, so it never wraps.
            case (state)
                IDLE: if (!rxd_s) cnt <= HALF_LOAD;
                START, DATA, STOP: cnt <= tc ? BIT_LOAD : cnt - CW'(1);
                default: cnt <= cnt;
            endcase

            if (state == START && tc) bit_idx <= 3'd0;
            if (state == DATA && tc) begin
                shift   <= {rxd_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            framing_err <= stop_bad;
            overrun     <= stop_ok && out_valid && !out_ready;

            if (stop_ok && (!out_valid || out_ready)) begin
                out_data  <= shift;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit; expectations are hand-derived
// cycle counts relative to the edge after which the start bit is driven.
module tb_uart_rx_byte;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid, busy, framing_err, overrun;

    uart_rx_byte #(.CLKS_PER_BIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .rxd(rxd), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .framing_err(framing_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor: accumulates event counts observed at the falling edge.
    int valid_cyc = 0, busy_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0;
    int rise_cyc = 0, ovr_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] rx_q[$];
    always @(negedge clk) begin
        prev_valid <= out_valid;
        if (out_valid) valid_cyc <= valid_cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (framing_err) ferr_cnt <= ferr_cnt + 1;
        if (overrun) begin
            ovr_cnt <= ovr_cnt + 1;
            ovr_cyc <= cyc;
        end
        if (out_valid && !prev_valid) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc <= cyc;
            rx_q.push_back(out_data);
        end
    end

    int total = 0, bad = 0;
    int b_valid, b_busy, b_ferr, b_ovr, b_rise, b_q;
    int t1, t2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mark();
        b_valid = valid_cyc; b_busy = busy_cyc; b_ferr = ferr_cnt;
        b_ovr = ovr_cnt; b_rise = rise_cnt; b_q = rx_q.size();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) rxd = 1'b0;
            else if (k == 9) rxd = stop_bit;
            else rxd = b[k-1];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        check("idle_busy", busy, 0);

        // Clean 0xA5 with consumer always ready.
        out_ready = 1'b1;
        mark();
        send_frame(8'hA5, 1'b1, t1);
        tick(5);
        check("a5_rises", rise_cnt - b_rise, 1);
        check("a5_data", rx_q[b_q], 8'hA5);
        check("a5_latency", rise_cyc - t1, 155);
        check("a5_valid_len", valid_cyc - b_valid, 1);
        check("a5_ferr", ferr_cnt - b_ferr, 0);
        check("a5_ovr", ovr_cnt - b_ovr, 0);

        // 4-cycle low glitch on an idle line.
        mark();
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        check("glitch_busy_len", busy_cyc - b_busy, 8);
        check("glitch_rises", rise_cnt - b_rise, 0);
        check("glitch_ferr", ferr_cnt - b_ferr, 0);

        // Stop bit low, line then held low for a break.
        mark();
        send_frame(8'h3C, 1'b0, t1);
        tick(40);
        rxd = 1'b1;
        tick(20);
        check("brk_ferr", ferr_cnt - b_ferr, 1);
        check("brk_rises", rise_cnt - b_rise, 0);
        check("brk_busy_len", busy_cyc - b_busy, 200);
        check("brk_idle", busy, 0);

        // Consumer stalled: second byte overruns.
        out_ready = 1'b0;
        mark();
        send_frame(8'h11, 1'b1, t1);
        send_frame(8'h22, 1'b1, t2);
        tick(5);
        check("ovr_rises", rise_cnt - b_rise, 1);
        check("ovr_first", rx_q[b_q], 8'h11);
        check("ovr_hold_data", out_data, 8'h11);
        check("ovr_hold_valid", out_valid, 1);
        check("ovr_cnt", ovr_cnt - b_ovr, 1);
        check("ovr_time", ovr_cyc - t2, 155);
        out_ready = 1'b1;
        tick(1);
        check("ovr_consumed", out_valid, 0);
        tick(5);

        // Back-to-back 0x00 then 0xFF, no gap.
        mark();
        send_frame(8'h00, 1'b1, t1);
        send_frame(8'hFF, 1'b1, t2);
        tick(5);
        check("b2b_rises", rise_cnt - b_rise, 2);
        check("b2b_first", rx_q[b_q], 8'h00);
        check("b2b_second", rx_q[b_q+1], 8'hFF);
        check("b2b_latency", rise_cyc - t2, 155);
        check("b2b_ferr", ferr_cnt - b_ferr, 0);
        check("b2b_ovr", ovr_cnt - b_ovr, 0);

        // Hold a byte, then reset mid-DATA of a following frame.
        out_ready = 1'b0;
        send_frame(8'hC3, 1'b1, t1);
        tick(5);
        rxd = 1'b0;
        tick(16);
        rxd = 1'b1;
        tick(16);
        rxd = 1'b0;
        tick(20);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_data", out_data, 8'hC3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 8'h00);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick(5);
        out_ready = 1'b1;
        mark();
        send_frame(8'h5A, 1'b1, t1);
        tick(5);
        check("post_rst_rises", rise_cnt - b_rise, 1);
        check("post_rst_data", rx_q[b_q], 8'h5A);
        check("post_rst_latency", rise_cyc - t1, 155);
        check("post_rst_ferr", ferr_cnt - b_ferr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Hand-written RS-232 receiver that deframes 8N1 serial bytes from the UART_RXD pin into a parallel byte stream with valid/ready handshake. It is the receive end of the board UART link: the PC transmits RSA key and ciphertext bytes, and this block delivers them to on-chip logic without going through the Qsys UART. It includes a metastability synchroniser, start-bit glitch rejection, framing-error detection and a one-entry output holding register with overrun reporting.

Parameters:
CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 baud); legal minimum 4.
HALF_BIT, CLKS_PER_BIT/2 (integer divide), cycles from start edge to start-bit centre sample.

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst_n  input  1  asynchronous active-low reset
rxd  input  1  raw serial line, idle high, asynchronous to clk
out_data  output  8  received byte, LSB = first data bit on the line
out_valid  output  1  out_data holds an unconsumed byte
out_ready  input  1  consumer accepts byte when out_valid && out_ready
busy  output  1  high while a frame is being received (state != IDLE)
framing_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped because holding register still full

Behaviour:
- Reset (async, rst_n=0): both synchroniser flops = 1, state=IDLE, bit counter=0, cycle counter=0, shift reg=0, out_data=8'h00, out_valid=0, busy=0, framing_err=0, overrun=0.
- Synchroniser: rxd passes two flops -> rxd_s (2-cycle delay). All decisions use rxd_s only.
- Timing reference T0 = first cycle with rxd_s==0 while state==IDLE.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rxd_s==0 -> START, cycle counter cleared.
- START: at T0+HALF_BIT sample rxd_s. If 0 -> DATA, counter cleared, bit index=0. If 1 -> IDLE (glitch, no error flag).
- DATA: data bit i (0..7) sampled at T0+HALF_BIT+(i+1)*CLKS_PER_BIT and shifted in LSB first. After bit 7 -> STOP.
- STOP: sampled at T0+HALF_BIT+9*CLKS_PER_BIT. If 1 -> deliver byte and go to IDLE. If 0 -> framing_err pulses high for exactly that cycle+1 (registered), byte is discarded, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxd_s==1, then go to IDLE (a break condition never produces bytes or repeated errors).
- Delivery: if the holding register is empty, or out_valid && out_ready in the same cycle as the stop sample, then out_data <= byte and out_valid=1 in the following cycle (latency: out_valid rises at T0+HALF_BIT+9*CLKS_PER_BIT+1). Otherwise the new byte is dropped, out_data/out_valid are unchanged, and overrun pulses for 1 cycle.
- Handshake: out_valid stays high and out_data stays stable until a cycle with out_ready=1; it deasserts the next cycle unless a new byte is delivered that same cycle. out_ready while out_valid=0 is ignored.
- Back-to-back frames: the STOP->IDLE transition occurs on the stop-sample cycle. A start edge at any later cycle is accepted, so no idle time beyond the half stop bit is required.
- busy = (state != IDLE), registered along with state.
- Counters: cycle counter width = clog2(CLKS_PER_BIT); no wrap issues because it is cleared at every sample point.
- rxd activity during DATA has no effect except at sample points (single-sample, no majority vote).

Test Plan:
- CLKS_PER_BIT=16: send 0xA5 (8N1) with out_ready=1 -> out_data=0xA5 and out_valid high exactly 1 cycle at T0+8+144+1; framing_err=0, overrun=0.
- Low glitch of 4 cycles on idle line -> busy high for ~8 cycles, returns to IDLE, no out_valid, no framing_err.
- Send 0x3C with stop bit forced 0, then hold line low 40 cycles -> single framing_err pulse, no out_valid, busy high until rxd_s returns 1.
- out_ready=0, send 0x11 then 0x22 back to back -> out_data stays 0x11, overrun pulses once at the second stop sample; raise out_ready -> 0x11 consumed, out_valid drops.
- Send 0x00 and 0xFF consecutively with zero inter-frame gap and out_ready=1 -> both bytes delivered in order, no errors.
- Assert rst_n=0 mid-DATA of a frame -> all outputs return to reset values immediately; the next clean frame 0x5A is received correctly.
